// File: rtl/aes_round_key_store_if.sv
// Round-key replay handshake between the key store and the decrypt datapath.
//   rk_byte  : replayed round-key byte
//   rk_valid : rk_byte is valid
//   rk_ready : consumer accepts rk_byte
//   rk_round : round index of rk_byte
//   rk_last  : final byte of the replay
// master = key store (producer), slave = datapath (consumer).
interface aes_round_key_store_if;
    logic [7:0] rk_byte;
    logic       rk_valid;
    logic       rk_ready;
    logic [3:0] rk_round;
    logic       rk_last;

    modport master (
        output rk_byte,
        output rk_valid,
        input  rk_ready,
        output rk_round,
        output rk_last
    );

    modport slave (
        input  rk_byte,
        input  rk_valid,
        output rk_ready,
        input  rk_round,
        input  rk_last
    );
endinterface

// File: rtl/aes_round_key_store.sv
// AES round-key store: captures the (NR+1)*NB expanded key bytes from the byte-serial
// key expander and replays them, one byte per handshake, in decryption order
// (round NR first, round 0 last; bytes 0..NB-1 within a round, byte 0 = MSB).
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   flush       : discard stored keys, return to EMPTY
//   kx_byte     : key byte from the expander
//   kx_valid    : kx_byte valid (no backpressure)
//   keys_ready  : all key bytes stored
//   overflow    : sticky, kx_valid seen while FULL or READ
//   rd_start    : pulse that starts a replay (only honoured when FULL)
//   rd_fwd      : (RK_FWD_REPLAY_EN only) replay ascending, round 0 first
//   rk          : replay handshake (aes_round_key_store_if.master)
//
// Optional feature macro: RK_FWD_REPLAY_EN adds rd_fwd for encrypt-order replay.
module aes_round_key_store #(
    parameter int unsigned NR = 10,
    parameter int unsigned NB = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [7:0]                   kx_byte,
    input  logic                         kx_valid,
    output logic                         keys_ready,
    output logic                         overflow,
    input  logic                         rd_start,
`ifdef RK_FWD_REPLAY_EN
    input  logic                         rd_fwd,
`endif
    aes_round_key_store_if.master        rk
);
    localparam int unsigned Total = (NR + 1) * NB;
    localparam int unsigned AW    = $clog2(Total);
    localparam int unsigned IW    = $clog2(NB);

    typedef enum logic [1:0] {StEmpty, StFill, StFull, StRead} state_e;

    state_e        state;
    logic [7:0]    mem [Total];
    logic [AW-1:0] wr_cnt;
    logic [3:0]    rd_round;
    logic [IW-1:0] rd_idx;
    logic          fwd;
    logic [7:0]    out_byte;
    logic          out_valid;
    logic          out_last;
    logic          ready_q;
    logic          ovf_q;

    logic          start_fwd;
    logic [3:0]    start_round;
    logic [3:0]    last_round;
    logic [3:0]    nxt_round;
    logic [IW-1:0] nxt_idx;
    logic          nxt_last;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] nxt_addr;
    logic          wr_en;

`ifdef RK_FWD_REPLAY_EN
    assign start_fwd = rd_fwd;
`else
    assign start_fwd = 1'b0;
`endif

    function automatic logic [AW-1:0] addr_of(input logic [3:0] round, input logic [IW-1:0] idx);
        return AW'(32'(round) * NB + 32'(idx));
    endfunction

    assign start_round = start_fwd ? 4'd0 : 4'(NR);
    assign last_round  = fwd ? 4'(NR) : 4'd0;
    assign start_addr  = addr_of(start_round, '0);

    // Successor of the byte currently presented; the round steps when the byte index wraps.
    always_comb begin
        nxt_idx   = rd_idx + IW'(1);
        nxt_round = rd_round;
        if (rd_idx == IW'(NB - 1)) begin
            nxt_idx   = '0;
            nxt_round = fwd ? rd_round + 4'd1 : rd_round - 4'd1;
        end
    end

    assign nxt_addr = addr_of(nxt_round, nxt_idx);
    assign nxt_last = (nxt_round == last_round) && (nxt_idx == IW'(NB - 1));

    // A kx_valid coinciding with flush/rst is dropped.
    assign wr_en = kx_valid && !rst && !flush && (state == StEmpty || state == StFill);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_cnt] <= kx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state     <= StEmpty;
            wr_cnt    <= '0;
            rd_round  <= '0;
            rd_idx    <= '0;
            fwd       <= 1'b0;
            out_byte  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            ready_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            unique case (state)
                StEmpty: begin
                    if (kx_valid) begin
                        wr_cnt <= AW'(1);
                        state  <= StFill;
                    end
                end
                StFill: begin
                    if (kx_valid) begin
                        if (wr_cnt == AW'(Total - 1)) begin
                            state   <= StFull;
                            ready_q <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + AW'(1);
                        end
                    end
                end
                StFull: begin
                    if (kx_valid) begin
                        ovf_q <= 1'b1;
                    end
                    if (rd_start) begin
                        state     <= StRead;
                        fwd       <= start_fwd;
                        rd_round  <= start_round;
                        rd_idx    <= '0;
                        out_byte  <= mem[start_addr];
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                    end
                end
                StRead: begin
                    if (kx_valid) begin
                        ovf_q <= 1'b1;
                    end
                    if (out_valid && rk.rk_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= StFull;
                        end else begin
                            rd_round <= nxt_round;
                            rd_idx   <= nxt_idx;
                            out_byte <= mem[nxt_addr];
                            out_last <= nxt_last;
                        end
                    end
                end
                default: state <= StEmpty;
            endcase
        end
    end

    assign keys_ready  = ready_q;
    assign overflow    = ovf_q;
    assign rk.rk_byte  = out_byte;
    assign rk.rk_valid = out_valid;
    assign rk.rk_round = rd_round;
    assign rk.rk_last  = out_last;
endmodule

// File: tb/tb_aes_round_key_store.sv
// Self-checking bench for aes_round_key_store: FIPS-197 key schedule reference computed here,
// table vectors from the FIPS-197 example, plus randomized fills and consumer backpressure.
module tb_aes_round_key_store;
    localparam int NR    = 10;
    localparam int NB    = 16;
    localparam int TOTAL = 176;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] kx_byte;
    logic       kx_valid;
    logic       keys_ready;
    logic       overflow;
    logic       rd_start;
`ifdef RK_FWD_REPLAY_EN
    logic       rd_fwd;
`endif

    always #5 clk = ~clk;

    aes_round_key_store_if rk_if ();

    aes_round_key_store dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .kx_byte    (kx_byte),
        .kx_valid   (kx_valid),
        .keys_ready (keys_ready),
        .overflow   (overflow),
        .rd_start   (rd_start),
`ifdef RK_FWD_REPLAY_EN
        .rd_fwd     (rd_fwd),
`endif
        .rk         (rk_if)
    );

    typedef struct {
        int         idx;
        logic [7:0] b;
        logic [3:0] rnd;
        logic       lst;
    } vec_t;

    vec_t       vecs[$];
    vec_t       vecs_fwd[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sbox     [256];
    logic [7:0] ref_mem  [TOTAL];
    logic [7:0] exp_byte [TOTAL];
    logic [3:0] exp_round[TOTAL];
    logic       exp_last [TOTAL];
    logic [7:0] got_byte [TOTAL];
    logic [3:0] got_round[TOTAL];
    logic       got_last [TOTAL];
    int         got_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [7:0] t[4];
        logic [7:0] rc;
        logic [7:0] t0;
        rc = 8'h01;
        for (int j = 0; j < 16; j++) ref_mem[j] = key[127 - 8 * j -: 8];
        for (int i = 16; i < TOTAL; i += 4) begin
            for (int j = 0; j < 4; j++) t[j] = ref_mem[i - 4 + j];
            if (i % 16 == 0) begin
                t0   = t[0];
                t[0] = sbox[t[1]] ^ rc;
                t[1] = sbox[t[2]];
                t[2] = sbox[t[3]];
                t[3] = sbox[t0];
                rc   = xtime(rc);
            end
            for (int j = 0; j < 4; j++) ref_mem[i + j] = ref_mem[i - 16 + j] ^ t[j];
        end
    endtask

    task automatic build_exp(input bit fwd);
        int k;
        int r;
        k = 0;
        for (int s = 0; s <= NR; s++) begin
            r = fwd ? s : NR - s;
            for (int b = 0; b < NB; b++) begin
                exp_byte[k]  = ref_mem[r * NB + b];
                exp_round[k] = 4'(r);
                exp_last[k]  = (s == NR) && (b == NB - 1);
                k++;
            end
        end
    endtask

    task automatic add_round(input int base, input logic [3:0] rnd, input logic [127:0] bytes);
        vec_t v;
        for (int j = 0; j < 16; j++) begin
            v.idx = base + j;
            v.b   = bytes[127 - 8 * j -: 8];
            v.rnd = rnd;
            v.lst = 1'b0;
            vecs.push_back(v);
        end
    endtask

    task automatic table_check(input string tag, input vec_t tv[$]);
        for (int i = 0; i < tv.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, tv[i].idx), 32'(got_byte[tv[i].idx]), 32'(tv[i].b));
            check($sformatf("%s_round%0d", tag, tv[i].idx), 32'(got_round[tv[i].idx]),
                  32'(tv[i].rnd));
            check($sformatf("%s_last%0d", tag, tv[i].idx), 32'(got_last[tv[i].idx]),
                  32'(tv[i].lst));
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // gap_mode: 0 contiguous, 1 two idle cycles per byte (1-in-3), 2 random gaps.
    task automatic fill(input int gap_mode, input int rd_start_at);
        int early;
        int rkv;
        int g;
        early = 0;
        rkv   = 0;
        for (int i = 0; i < TOTAL; i++) begin
            g = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (g) begin
                kx_valid = 1'b0;
                @(negedge clk);
                if (keys_ready) early++;
                if (rk_if.rk_valid) rkv++;
            end
            kx_valid = 1'b1;
            kx_byte  = ref_mem[i];
            rd_start = (i == rd_start_at);
            @(negedge clk);
            rd_start = 1'b0;
            if (i < TOTAL - 1 && keys_ready) early++;
            if (rk_if.rk_valid) rkv++;
        end
        kx_valid = 1'b0;
        check("keys_ready_early", 32'(early), 32'd0);
        check("keys_ready_rise", 32'(keys_ready), 32'd1);
        check("fill_no_rk_valid", 32'(rkv), 32'd0);
    endtask

    // mode: 0 always ready, 1 five-cycle stall at byte 3, 2 random ready.
    task automatic replay(input int mode, input bit fwd, input int abort_at);
        int         n;
        int         cyc;
        int         stall;
        int         bad_hold;
        int         late;
        bit         done;
        bit         rdy;
        bit         hold;
        logic [13:0] held;
        build_exp(fwd);
        n = 0; cyc = 0; stall = 0; bad_hold = 0; done = 1'b0; hold = 1'b0; held = '0;
`ifdef RK_FWD_REPLAY_EN
        rd_fwd = fwd;
`endif
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        check("start_latency", 32'(rk_if.rk_valid), 32'd1);
        while (!done && cyc < 2000) begin
            if (abort_at >= 0 && n == abort_at) begin
                flush = 1'b1;
                rk_if.rk_ready = 1'b0;
                @(negedge clk);
                flush = 1'b0;
                check("abort_rk_valid", 32'(rk_if.rk_valid), 32'd0);
                check("abort_keys_ready", 32'(keys_ready), 32'd0);
                check("abort_overflow", 32'(overflow), 32'd0);
                late = 0;
                repeat (3) begin
                    @(negedge clk);
                    if (rk_if.rk_valid) late++;
                end
                check("abort_quiet", 32'(late), 32'd0);
                got_n = n;
                return;
            end
            case (mode)
                1: begin
                    rdy = 1'b1;
                    if (n == 3 && stall < 5) begin
                        if (stall == 0) begin
                            check("stall_byte", 32'(rk_if.rk_byte), 32'(exp_byte[3]));
                            check("stall_round", 32'(rk_if.rk_round), 32'(exp_round[3]));
                        end
                        rdy = 1'b0;
                        stall++;
                    end
                end
                2: rdy = ($urandom_range(0, 3) != 0);
                default: rdy = 1'b1;
            endcase
            rk_if.rk_ready = rdy;
            if (hold && {rk_if.rk_valid, rk_if.rk_byte, rk_if.rk_round, rk_if.rk_last} !== held)
                bad_hold++;
            if (rk_if.rk_valid && rdy && n < TOTAL) begin
                got_byte[n]  = rk_if.rk_byte;
                got_round[n] = rk_if.rk_round;
                got_last[n]  = rk_if.rk_last;
                n++;
                if (rk_if.rk_last) done = 1'b1;
            end
            hold = rk_if.rk_valid && !rdy;
            held = {rk_if.rk_valid, rk_if.rk_byte, rk_if.rk_round, rk_if.rk_last};
            @(negedge clk);
            cyc++;
        end
        rk_if.rk_ready = 1'b0;
        got_n = n;
        check("replay_done", 32'(done), 32'd1);
        check("end_rk_valid", 32'(rk_if.rk_valid), 32'd0);
        check("end_rk_last", 32'(rk_if.rk_last), 32'd0);
        check("end_keys_ready", 32'(keys_ready), 32'd1);
        if (mode == 0) check("throughput_cycles", 32'(cyc), 32'(TOTAL));
        if (mode != 0) check("hold_stable", 32'(bad_hold), 32'd0);
    endtask

    task automatic compare_replay(input string tag);
        int mism;
        int first;
        mism  = 0;
        first = -1;
        check({tag, "_len"}, 32'(got_n), 32'(TOTAL));
        for (int i = 0; i < got_n && i < TOTAL; i++) begin
            if (got_byte[i] !== exp_byte[i] || got_round[i] !== exp_round[i] ||
                got_last[i] !== exp_last[i]) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        if (first >= 0)
            $display("note %s first diff at %0d: got %h/%0d/%0b want %h/%0d/%0b", tag, first,
                     got_byte[first], got_round[first], got_last[first], exp_byte[first],
                     exp_round[first], exp_last[first]);
        check({tag, "_data_mismatches"}, 32'(mism), 32'd0);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; flush = 1'b0; kx_byte = 8'h00; kx_valid = 1'b0; rd_start = 1'b0;
        rk_if.rk_ready = 1'b0;
`ifdef RK_FWD_REPLAY_EN
        rd_fwd = 1'b0;
`endif
        add_round(0, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        add_round(16, 4'd9, 128'h549932d1f085576810_93ed9cbe2c974e);
        v.idx = 175; v.b = 8'h0f; v.rnd = 4'd0; v.lst = 1'b1;
        vecs.push_back(v);
        for (int j = 0; j < 16; j++) begin
            v.idx = j; v.b = 8'(j); v.rnd = 4'd0; v.lst = 1'b0;
            vecs_fwd.push_back(v);
        end
        v.idx = 175; v.b = 8'hc5; v.rnd = 4'd10; v.lst = 1'b1;
        vecs_fwd.push_back(v);
        build_sbox();

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_keys_ready", 32'(keys_ready), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_rk_valid", 32'(rk_if.rk_valid), 32'd0);
        check("rst_rk_last", 32'(rk_if.rk_last), 32'd0);
        check("rst_rk_round", 32'(rk_if.rk_round), 32'd0);
        check("rst_rk_byte", 32'(rk_if.rk_byte), 32'd0);

        // Contiguous FIPS-197 fill and in-order replay.
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        fill(0, -1);
        check("fill_overflow", 32'(overflow), 32'd0);
        replay(0, 1'b0, -1);
        compare_replay("fips");
        table_check("fips_tbl", vecs);

        // Backpressure at byte 3, then a second back-to-back replay.
        replay(1, 1'b0, -1);
        compare_replay("stall");
        replay(0, 1'b0, -1);
        compare_replay("repeat");

        // kx_valid while FULL must not disturb stored keys.
        kx_valid = 1'b1;
        kx_byte  = 8'haa;
        @(negedge clk);
        kx_valid = 1'b0;
        check("overflow_set", 32'(overflow), 32'd1);
        replay(2, 1'b0, -1);
        compare_replay("after_overflow");
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Flush at byte 40 of a replay, then a gapped refill with a stray rd_start.
        replay(0, 1'b0, 40);
        fill(1, 5);
        replay(0, 1'b0, -1);
        compare_replay("gapped");
        table_check("gapped_tbl", vecs);

        // Random key material, random gaps, random consumer backpressure.
        for (int it = 0; it < 3; it++) begin
            do_flush();
            for (int i = 0; i < TOTAL; i++) ref_mem[i] = 8'($urandom);
            fill(2, -1);
            replay(2, 1'b0, -1);
            compare_replay($sformatf("rand%0d", it));
        end

`ifdef RK_FWD_REPLAY_EN
        do_flush();
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        fill(0, -1);
        replay(2, 1'b1, -1);
        compare_replay("fwd");
        table_check("fwd_tbl", vecs_fwd);
        replay(0, 1'b0, -1);
        compare_replay("fwd_then_rev");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
